// File: rtl/alu_control.sv
// Registered ALU operation decoder: {ALUop, funct} -> 3-bit ALU control code one clock later.
// Define ALU_CTRL_ERRCNT_EN to add the saturating illegal-op counter on err_cnt.
module alu_control #(
  parameter int          ERRCNT_W     = 8,
  parameter logic [2:0]  ILLEGAL_CTRL = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [1:0]          ALUop,
  input  logic [3:0]          funct,
  output logic [2:0]          ctrl,
  output logic                out_valid,
`ifdef ALU_CTRL_ERRCNT_EN
  output logic                illegal,
  output logic [ERRCNT_W-1:0] err_cnt
`else
  output logic                illegal
`endif
);

  typedef enum logic [1:0] {
    OP_MEM    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_RTYPE  = 2'b10,
    OP_IMM    = 2'b11
  } aluop_e;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;

  logic [2:0] dec_ctrl;
  logic       dec_illegal;

  logic [2:0] ctrl_d, ctrl_q;
  logic       out_valid_d, out_valid_q;
  logic       illegal_d, illegal_q;

  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (aluop_e'(ALUop))
      OP_MEM:    dec_ctrl = CTRL_ADD;
      OP_BRANCH: dec_ctrl = CTRL_SUB;
      OP_RTYPE: begin
        // Low half of the R-type function space maps straight onto the ctrl encoding.
        if (!funct[3]) begin
          dec_ctrl = funct[2:0];
        end else begin
          dec_ctrl    = ILLEGAL_CTRL;
          dec_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        case (funct)
          4'b0000: dec_ctrl = CTRL_AND;
          4'b0001: dec_ctrl = CTRL_OR;
          4'b0010: dec_ctrl = CTRL_ADD;
          default: begin
            dec_ctrl    = ILLEGAL_CTRL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = ILLEGAL_CTRL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q      <= 3'b000;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;

`ifdef ALU_CTRL_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_d, err_cnt_q;

  // Counter sticks at all-ones rather than wrapping back to zero.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && dec_illegal && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control; covers the counter when ALU_CTRL_ERRCNT_EN is defined.
module tb_alu_control;

`ifdef ALU_CTRL_ERRCNT_EN
  localparam int ERRCNT_W = 2;
`else
  localparam int ERRCNT_W = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] ALUop;
  logic [3:0] funct;
  logic [2:0] ctrl;
  logic       out_valid;
  logic       illegal;
`ifdef ALU_CTRL_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control #(
    .ERRCNT_W     (ERRCNT_W),
    .ILLEGAL_CTRL (3'b000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ALUop     (ALUop),
    .funct     (funct),
    .ctrl      (ctrl),
    .out_valid (out_valid),
`ifdef ALU_CTRL_ERRCNT_EN
    .illegal   (illegal),
    .err_cnt   (err_cnt)
`else
    .illegal   (illegal)
`endif
  );

  // Drive one set of inputs, let one rising edge take them, then settle past the edge.
  task automatic applyStimulus(input logic rst_v, input logic valid_v,
                               input logic [1:0] op_v, input logic [3:0] fn_v);
    rst_n    = rst_v;
    in_valid = valid_v;
    ALUop    = op_v;
    funct    = fn_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_ctrl,
                             input logic exp_valid, input logic exp_illegal);
    checks++;
    assert (ctrl === exp_ctrl) else begin
      errors++;
      $display("[TB] FAIL %s ctrl got=%b expected=%b", tag, ctrl, exp_ctrl);
      $error("[TB] %s ctrl", tag);
    end
    checks++;
    assert (out_valid === exp_valid) else begin
      errors++;
      $display("[TB] FAIL %s out_valid got=%b expected=%b", tag, out_valid, exp_valid);
      $error("[TB] %s out_valid", tag);
    end
    checks++;
    assert (illegal === exp_illegal) else begin
      errors++;
      $display("[TB] FAIL %s illegal got=%b expected=%b", tag, illegal, exp_illegal);
      $error("[TB] %s illegal", tag);
    end
  endtask

`ifdef ALU_CTRL_ERRCNT_EN
  task automatic checkErrCnt(input string tag, input logic [ERRCNT_W-1:0] exp_cnt);
    checks++;
    assert (err_cnt === exp_cnt) else begin
      errors++;
      $display("[TB] FAIL %s err_cnt got=%0d expected=%0d", tag, err_cnt, exp_cnt);
      $error("[TB] %s err_cnt", tag);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUop    = 2'b00;
    funct    = 4'b0000;
    #2;

    $display("[TB] reset with a valid R-type OR presented");
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0011);
    checkOutput("reset0", 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b0011);
    checkOutput("reset1", 3'b000, 1'b0, 1'b0);

    $display("[TB] class decode");
    applyStimulus(1'b1, 1'b1, 2'b00, 4'b0000);
    checkOutput("mem", 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'b0001);
    checkOutput("branch", 3'b001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b0001);
    checkOutput("rtype_sub", 3'b001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0001);
    checkOutput("ori", 3'b011, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 4'b1111);
    checkOutput("branch_ignores_funct", 3'b001, 1'b1, 1'b0);

    $display("[TB] R-type sweep");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b10, 4'(i));
      checkOutput($sformatf("rsweep%0d", i), 3'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b1010);
    checkOutput("rtype_illegal", 3'b000, 1'b1, 1'b1);

    $display("[TB] hold while in_valid is low");
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b0101);
    checkOutput("hold_load", 3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 4'b0000);
      checkOutput($sformatf("hold%0d", i), 3'b101, 1'b0, 1'b0);
    end

    $display("[TB] immediate decode");
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0111);
    checkOutput("imm_illegal", 3'b000, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 4'b0000);
    checkOutput("imm_illegal_hold", 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0000);
    checkOutput("andi", 3'b010, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0010);
    checkOutput("addi", 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0000);
    checkOutput("andi2", 3'b010, 1'b1, 1'b0);

    $display("[TB] reset beats a pending illegal input");
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b1100);
    checkOutput("midreset", 3'b000, 1'b0, 1'b0);
`ifdef ALU_CTRL_ERRCNT_EN
    checkErrCnt("cnt_after_reset", 2'd0);

    $display("[TB] saturating illegal counter");
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b1000);
    checkErrCnt("cnt1", 2'd1);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b0011);
    checkErrCnt("cnt2", 2'd2);
    applyStimulus(1'b1, 1'b0, 2'b11, 4'b0011);
    checkErrCnt("cnt_idle", 2'd2);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b1111);
    checkErrCnt("cnt3", 2'd3);
    applyStimulus(1'b1, 1'b1, 2'b11, 4'b1001);
    checkErrCnt("cnt_sat4", 2'd3);
    applyStimulus(1'b1, 1'b1, 2'b10, 4'b1011);
    checkErrCnt("cnt_sat5", 2'd3);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'b1011);
    checkErrCnt("cnt_reset", 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
